// File: rtl/levenshtein_pattern_loader.sv
// levenshtein_pattern_loader
// Builds the per-character match-bitvector table in external SRAM for the
// levenshtein controller. The host loads the search word through a small
// Wishbone slave. A start write then sweeps characters 0x02..0xFF and writes
// each vector as a big-endian Wishbone master burst.
// Optional feature macro: PATTERN_LOADER_CASE_FOLD_EN (ASCII case-insensitive match).
module levenshtein_pattern_loader #(
  parameter int MASTER_ADDR_WIDTH = 24,
  parameter int SLAVE_ADDR_WIDTH  = 24,
  parameter int BITVECTOR_WIDTH   = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  // master
  output logic                         wbm_cyc_o,
  output logic                         wbm_stb_o,
  output logic [MASTER_ADDR_WIDTH-1:0] wbm_adr_o,
  output logic                         wbm_we_o,
  output logic [7:0]                   wbm_dat_o,
  output logic [2:0]                   wbm_cti_o,
  output logic [1:0]                   wbm_bte_o,
  input  logic                         wbm_ack_i,
  input  logic                         wbm_err_i,
  input  logic                         wbm_rty_i,
  // slave
  input  logic                         wbs_cyc_i,
  input  logic                         wbs_stb_i,
  input  logic                         wbs_we_i,
  input  logic [SLAVE_ADDR_WIDTH-1:0]  wbs_adr_i,
  input  logic [7:0]                   wbs_dat_i,
  output logic                         wbs_ack_o,
  output logic [7:0]                   wbs_dat_o,
  output logic                         wbs_err_o,
  output logic                         wbs_rty_o,
  // status
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int BYTES = (BITVECTOR_WIDTH + 7) / 8;
  localparam int LW    = (BITVECTOR_WIDTH > 1) ? $clog2(BITVECTOR_WIDTH) : 1;
  localparam int KW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int PADW  = BYTES * 8;
  localparam int TAW   = 9 + ((BYTES > 1) ? KW : 0);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;

  state_t        state_q, state_d;
  logic [7:0]    char_q, char_d;
  logic [KW-1:0] k_q, k_d;
  logic          error_q, error_d;
  logic          done_q, done_d;
  logic [LW-1:0] len_q, ptr_q;
  logic [7:0]    buf_q [BITVECTOR_WIDTH];
  logic          ack_q;

  logic          busy;
  logic          wr_fire, start;
  logic [2:0]    reg_sel;
  logic [7:0]    rd_data;
  logic          k_last;
  logic [PADW-1:0] vec;
  logic [7:0]    vec_byte;
  logic [TAW-1:0] tbl_adr;
  logic          unused_adr;

  assign busy    = (state_q != S_IDLE);
  assign reg_sel = wbs_adr_i[2:0];
  // A write takes effect in the cycle its ack is presented, so a start write
  // leads to the first burst cycle right after the ack cycle.
  assign wr_fire = wbs_cyc_i & wbs_stb_i & wbs_we_i & ack_q;
  assign start   = wr_fire & ~busy & (reg_sel == 3'd0) & wbs_dat_i[0];
  assign unused_adr = &{1'b0, wbs_adr_i[SLAVE_ADDR_WIDTH-1:3]};

  // Character comparison key; folds upper-case ASCII onto lower-case when enabled.
  function automatic logic [7:0] fold(input logic [7:0] c);
`ifdef PATTERN_LOADER_CASE_FOLD_EN
    fold = (c >= 8'h41 && c <= 8'h5A) ? (c | 8'h20) : c;
`else
    fold = c;
`endif
  endfunction

  // Slave acknowledge: one registered pulse per access.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ack_q <= 1'b0;
    else         ack_q <= wbs_cyc_i & wbs_stb_i & ~ack_q;
  end

  // LENGTH and PTR registers; frozen while a load runs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      len_q <= '0;
      ptr_q <= '0;
    end else if (wr_fire && !busy) begin
      case (reg_sel)
        3'd1: len_q <= LW'(wbs_dat_i);
        3'd2: ptr_q <= LW'(wbs_dat_i);
        3'd3: ptr_q <= (int'(ptr_q) >= BITVECTOR_WIDTH - 1) ? '0 : ptr_q + LW'(1);
        default: ;
      endcase
    end
  end

  // Word buffer; contents after reset are irrelevant, so no reset here.
  always_ff @(posedge clk_i) begin
    if (wr_fire && !busy && reg_sel == 3'd3 && int'(ptr_q) < BITVECTOR_WIDTH)
      buf_q[ptr_q] <= wbs_dat_i;
  end

  // Slave read mux; data is only driven alongside the ack.
  always_comb begin
    rd_data = 8'h00;
    case (reg_sel)
      3'd0: rd_data = {6'b0, error_q, busy};
      3'd1: rd_data = 8'(len_q);
      3'd2: rd_data = 8'(ptr_q);
      3'd4: rd_data = char_q;
      default: rd_data = 8'h00;
    endcase
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = ack_q ? rd_data : 8'h00;
  assign wbs_err_o = 1'b0;
  assign wbs_rty_o = 1'b0;

  // Match vector for the current character; bits above LENGTH stay zero.
  always_comb begin
    vec = '0;
    for (int i = 0; i < BITVECTOR_WIDTH; i++) begin
      if (LW'(i) <= len_q && fold(buf_q[i]) == fold(char_q))
        vec[i] = 1'b1;
    end
  end

  // Big-endian byte select: k = 0 carries the most significant byte.
  assign vec_byte = 8'(vec >> ((BYTES - 1 - int'(k_q)) * 8));
  assign k_last   = (k_q == KW'(BYTES - 1));

  generate
    if (BYTES > 1) begin : g_multi
      assign tbl_adr = {1'b1, char_q, k_q};
    end else begin : g_single
      logic unused_k;
      assign unused_k = &{1'b0, k_q};
      assign tbl_adr  = {1'b1, char_q};
    end
  endgenerate

  // FSM state and load-progress registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      char_q  <= 8'h02;
      k_q     <= '0;
      error_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      char_q  <= char_d;
      k_q     <= k_d;
      error_q <= error_d;
      done_q  <= done_d;
    end
  end

  // FSM next state: burst per character, one idle gap between characters.
  always_comb begin
    state_d = state_q;
    char_d  = char_q;
    k_d     = k_q;
    error_d = error_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_BURST;
          char_d  = 8'h02;
          k_d     = '0;
          error_d = 1'b0;
        end
      end
      S_BURST: begin
        // an ack coinciding with err/rty is still an error
        if (wbm_err_i || wbm_rty_i) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else if (wbm_ack_i) begin
          if (!k_last) begin
            k_d = k_q + KW'(1);
          end else if (char_q == 8'hFF) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        char_d  = char_q + 8'h01;
        k_d     = '0;
        state_d = S_BURST;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Master outputs; address, data and cycle type are zero outside a burst.
  always_comb begin
    wbm_cyc_o = 1'b0;
    wbm_stb_o = 1'b0;
    wbm_we_o  = 1'b0;
    wbm_adr_o = '0;
    wbm_dat_o = 8'h00;
    wbm_cti_o = 3'b000;
    if (state_q == S_BURST) begin
      wbm_cyc_o = 1'b1;
      wbm_stb_o = 1'b1;
      wbm_we_o  = 1'b1;
      wbm_adr_o = MASTER_ADDR_WIDTH'(tbl_adr);
      wbm_dat_o = vec_byte;
      if (BYTES > 1) wbm_cti_o = k_last ? 3'b111 : 3'b010;
    end
  end

  assign wbm_bte_o = 2'b00;
  assign busy_o    = busy;
  assign done_o    = done_q;

endmodule

// File: tb/tb_levenshtein_pattern_loader.sv
// Randomized bench for levenshtein_pattern_loader (default parameters).
// A responder plays the SRAM and records every acked write into a table
// image, which is compared against vectors computed from the word buffer.
module tb_levenshtein_pattern_loader;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [23:0] wbm_adr_o;
  logic [7:0]  wbm_dat_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic        wbm_ack_i, wbm_err_i, wbm_rty_i;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [23:0] wbs_adr_i;
  logic [7:0]  wbs_dat_i;
  logic        wbs_ack_o, wbs_err_o, wbs_rty_o;
  logic [7:0]  wbs_dat_o;
  logic        busy_o, done_o;

  levenshtein_pattern_loader dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_adr_o(wbm_adr_o),
    .wbm_we_o(wbm_we_o), .wbm_dat_o(wbm_dat_o), .wbm_cti_o(wbm_cti_o),
    .wbm_bte_o(wbm_bte_o), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
    .wbm_rty_i(wbm_rty_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_ack_o(wbs_ack_o),
    .wbs_dat_o(wbs_dat_o), .wbs_err_o(wbs_err_o), .wbs_rty_o(wbs_rty_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_bad = 0;
  int ack_pct = 100;
  bit err_en = 1'b0;
  logic [9:0] err_adr = '0;
  int wr_cnt = 0, mcyc_cnt = 0, done_cnt = 0, proto_bad = 0;
  logic [7:0] mem [0:1023];

  // reference state: word buffer, LENGTH, PTR
  logic [7:0] buf_m [16];
  int len_m = 0, ptr_m = 0;
  logic [7:0] wq [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mfold(input logic [7:0] c);
`ifdef PATTERN_LOADER_CASE_FOLD_EN
    if (c >= "A" && c <= "Z") return c + 8'd32;
`endif
    return c;
  endfunction

  // expected vector: bit i set when i <= LENGTH and buf[i] matches c
  function automatic logic [15:0] mvec(input int c);
    logic [15:0] v = '0;
    for (int i = 0; i < 16; i++)
      if (i <= len_m && mfold(buf_m[i]) == mfold(8'(c))) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [15:0] tvec(input int c);
    return {mem[10'(512 + c * 2)], mem[10'(512 + c * 2 + 1)]};
  endfunction

  // SRAM responder and bus-rule monitor
  initial begin
    wbm_ack_i = 0; wbm_err_i = 0; wbm_rty_i = 0;
    forever begin
      @(posedge clk_i); #1;
      wbm_ack_i = 0; wbm_err_i = 0; wbm_rty_i = 0;
      if (wbm_cyc_o) begin
        mcyc_cnt++;
        if (wbm_stb_o !== 1'b1 || wbm_we_o !== 1'b1 || wbm_bte_o !== 2'b00 ||
            wbm_adr_o[23:10] != 0 || wbm_adr_o[9] !== 1'b1 ||
            wbm_cti_o !== (wbm_adr_o[0] ? 3'b111 : 3'b010))
          proto_bad++;
        if (err_en && wbm_adr_o[9:0] == err_adr) wbm_err_i = 1;
        else if ($urandom_range(0, 99) < ack_pct) begin
          wbm_ack_i = 1;
          mem[wbm_adr_o[9:0]] = wbm_dat_o;
          wr_cnt++;
        end
      end else if (wbm_stb_o || wbm_we_o || wbm_adr_o != 0 || wbm_dat_o != 0 || wbm_cti_o != 0)
        proto_bad++;
    end
  end

  initial forever begin
    @(posedge clk_i); #1;
    if (done_o) done_cnt++;
  end

  task automatic wb_xfer(input logic we, input logic [2:0] a, input logic [7:0] d,
                         output logic [7:0] q);
    int n = 0;
    @(posedge clk_i); #1;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we; wbs_adr_i = 24'(a); wbs_dat_i = d;
    do begin @(posedge clk_i); #1; n++; end while (!wbs_ack_o && n < 10);
    chk("slave_ack", wbs_ack_o, 1);
    q = wbs_dat_o;
    @(posedge clk_i); #1;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
  endtask

  task automatic wb_wr(input logic [2:0] a, input logic [7:0] d);
    logic [7:0] q;
    wb_xfer(1'b1, a, d, q);
  endtask

  task automatic wb_rd(input logic [2:0] a, output logic [7:0] q);
    wb_xfer(1'b0, a, 8'h00, q);
  endtask

  task automatic load_word(input int len);
    wb_wr(3'd2, 8'd0);
    ptr_m = 0;
    foreach (wq[i]) begin
      wb_wr(3'd3, wq[i]);
      buf_m[ptr_m] = wq[i];
      ptr_m = (ptr_m + 1) % 16;
    end
    wb_wr(3'd1, 8'(len));
    len_m = len;
  endtask

  task automatic prep_load(input int pct);
    ack_pct = pct;
    foreach (mem[i]) mem[i] = 'x;
    wr_cnt = 0;
    proto_bad = 0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt, n = 0;
    while (done_cnt == d0 && n < budget) begin @(posedge clk_i); #1; n++; end
    chk("done_seen", 32'(done_cnt != d0), 1);
  endtask

  task automatic check_table(input string tag);
    for (int c = 2; c < 256; c++) chk(tag, tvec(c), mvec(c));
    chk({tag, "_wr_cnt"}, wr_cnt, 508);
    chk({tag, "_proto"}, proto_bad, 0);
  endtask

  initial begin
    logic [7:0] q;
    int n, d0, m0;
    bit seen;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_adr_i = '0; wbs_dat_i = '0;
    rst_ni = 0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_cyc", wbm_cyc_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_ack", wbs_ack_o, 0);
    chk("rst_sdat", wbs_dat_o, 0);
    rst_ni = 1;
    wb_rd(3'd0, q); chk("rst_ctrl", q, 8'h00);
    wb_rd(3'd1, q); chk("rst_len", q, 8'h00);
    wb_rd(3'd2, q); chk("rst_ptr", q, 8'h00);
    wb_rd(3'd4, q); chk("rst_char", q, 8'h02);
    wb_rd(3'd6, q); chk("rd_unmapped", q, 8'h00);

    // "ab", zero wait states, exact cycle count
    wq = {8'h61, 8'h62};
    load_word(1);
    prep_load(100);
    wb_wr(3'd0, 8'h01);
    n = 1; seen = 0;
    while (!seen && n < 2000) begin
      if (done_o) begin
        seen = 1;
        chk("busy_at_done", busy_o, 0);
      end else begin
        @(posedge clk_i); #1; n++;
      end
    end
    chk("load_cycles", n, 762);
    chk("ab_2c2", mem[10'h2C2], 8'h00);
    chk("ab_2c3", mem[10'h2C3], 8'h01);
    chk("ab_2c4", mem[10'h2C4], 8'h00);
    chk("ab_2c5", mem[10'h2C5], 8'h02);
    chk("ab_2c6", mem[10'h2C6], 8'h00);
    chk("ab_2c7", mem[10'h2C7], 8'h00);
    check_table("ab_tbl");
    wb_rd(3'd0, q); chk("ab_ctrl", q, 8'h00);
    wb_rd(3'd4, q); chk("ab_char", q, 8'hFF);

    // "aaab", bits beyond LENGTH ignored
    wq = {8'h61, 8'h61, 8'h61, 8'h62};
    load_word(2);
    prep_load(100);
    wb_wr(3'd0, 8'h01);
    wait_done(2000);
    chk("aaab_a", tvec(8'h61), 16'h0007);
    chk("aaab_b", tvec(8'h62), 16'h0000);
    check_table("aaab_tbl");

    // 17 DATA bytes wrap PTR to 1, then random-wait load over full length
    wq.delete();
    for (int i = 0; i < 17; i++) wq.push_back(8'($urandom_range(8'h61, 8'h64)));
    load_word(15);
    wb_rd(3'd2, q); chk("ptr_wrap", q, 8'h01);
    prep_load($urandom_range(40, 90));
    wb_wr(3'd0, 8'h01);
    wait_done(5000);
    check_table("wrap_tbl");

    // random words / lengths / wait states; the first one gets writes while busy
    for (int t = 0; t < 3; t++) begin
      wq.delete();
      for (int i = 0; i < 16; i++)
        wq.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom_range(8'h41, 8'h44))
                                                 : 8'($urandom_range(8'h61, 8'h64)));
      load_word($urandom_range(0, 15));
      wb_wr(3'd2, 8'(ptr_m ^ 3));
      ptr_m = ptr_m ^ 3;
      prep_load($urandom_range(30, 100));
      wb_wr(3'd0, 8'h01);
      if (t == 0) begin
        wb_wr(3'd0, 8'h01);
        wb_wr(3'd3, 8'hEE);
        wb_wr(3'd1, 8'h00);
        wb_wr(3'd2, 8'h05);
        chk("busy_mid", busy_o, 1);
      end
      wait_done(6000);
      check_table($sformatf("rnd%0d_tbl", t));
      wb_rd(3'd1, q); chk("len_kept", q, 8'(len_m));
      wb_rd(3'd2, q); chk("ptr_kept", q, 8'(ptr_m));
    end

    // "aB": case folding (or exact match without it)
    wq = {8'h61, 8'h42};
    load_word(1);
    prep_load(100);
    wb_wr(3'd0, 8'h01);
    wait_done(2000);
`ifdef PATTERN_LOADER_CASE_FOLD_EN
    chk("fold_A", tvec(8'h41), 16'h0001);
    chk("fold_a", tvec(8'h61), 16'h0001);
    chk("fold_b", tvec(8'h62), 16'h0002);
    chk("fold_B", tvec(8'h42), 16'h0002);
`else
    chk("exact_A", tvec(8'h41), 16'h0000);
    chk("exact_a", tvec(8'h61), 16'h0001);
    chk("exact_b", tvec(8'h62), 16'h0000);
    chk("exact_B", tvec(8'h42), 16'h0002);
`endif
    check_table("case_tbl");

    // bus error on the second byte of char 0x05
    prep_load(100);
    err_adr = 10'h20B;
    err_en = 1;
    d0 = done_cnt;
    wb_wr(3'd0, 8'h01);
    n = 0;
    while (!wbm_err_i && n < 200) begin @(posedge clk_i); #2; n++; end
    chk("err_reached", wbm_err_i, 1);
    @(posedge clk_i); #2;
    chk("err_cyc_drop", wbm_cyc_o, 0);
    chk("err_busy", busy_o, 0);
    m0 = mcyc_cnt;
    repeat (20) @(posedge clk_i);
    #2;
    chk("err_no_more_cycles", mcyc_cnt, m0);
    chk("err_no_done", done_cnt, d0);
    err_en = 0;
    wb_rd(3'd0, q); chk("err_ctrl", q, 8'h02);

    // a new start clears the error flag
    prep_load(100);
    wb_wr(3'd0, 8'h01);
    wb_rd(3'd0, q); chk("restart_ctrl", q, 8'h01);
    wait_done(2000);
    check_table("restart_tbl");

    // asynchronous reset in the middle of a burst
    prep_load(70);
    wb_wr(3'd0, 8'h01);
    n = 0;
    while (!wbm_cyc_o && n < 50) begin @(posedge clk_i); #1; n++; end
    chk("pre_rst_cyc", wbm_cyc_o, 1);
    #3 rst_ni = 0;
    #1;
    chk("async_rst_cyc", wbm_cyc_o, 0);
    chk("async_rst_busy", busy_o, 0);
    @(posedge clk_i); #1;
    rst_ni = 1;
    wb_rd(3'd0, q); chk("post_rst_ctrl", q, 8'h00);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
